// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered RV32I/RV64I decode stage with valid/ready handshake,
//            one-entry skid buffer and flush. Optional illegal-instruction
//            detection is enabled by defining DECODE_ILLEGAL_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int  N               = 32,
    parameter int  REG_W           = 5,
    localparam int ALU_FUNCT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [N-1:0]               in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_pc,
    output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
    output logic [REG_W-1:0]           rs1,
    output logic [REG_W-1:0]           rs2,
    output logic [REG_W-1:0]           rd,
    output logic [N-1:0]               immed,
    output logic                       alu_src_imm,
    output logic                       reg_write,
    output logic                       is_load,
    output logic                       is_store,
    output logic                       is_branch,
    output logic                       is_jal,
    output logic                       is_jalr,
    output logic                       is_lui,
    output logic                       is_auipc,
    output logic                       illegal,
    output logic [7:0]                 illegal_count
);

    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_ADD  = 4'd0;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SUB  = 4'd1;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_AND  = 4'd2;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_OR   = 4'd3;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_XOR  = 4'd4;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLT  = 4'd5;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLTU = 4'd6;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SLL  = 4'd7;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SRL  = 4'd8;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SRA  = 4'd9;

    localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_ALU_REG = 7'b0110011;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SRL  = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT1 = 7'b0100000;

    localparam int SHAMT_W = $clog2(N);

    typedef struct packed {
        logic [N-1:0]               pc;
        logic [ALU_FUNCT_WIDTH-1:0] alu_funct;
        logic [REG_W-1:0]           rs1;
        logic [REG_W-1:0]           rs2;
        logic [REG_W-1:0]           rd;
        logic [N-1:0]               immed;
        logic                       alu_src_imm;
        logic                       reg_write;
        logic                       is_load;
        logic                       is_store;
        logic                       is_branch;
        logic                       is_jal;
        logic                       is_jalr;
        logic                       is_lui;
        logic                       is_auipc;
`ifdef DECODE_ILLEGAL_DETECT_EN
        logic                       illegal;
`endif
    } dec_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  funct7_eff;
    logic        is_alu_reg;
    logic        is_alu_imm;
    logic        is_shift_imm;
    logic [31:0] imm32;
    dec_t        dec;

    assign opcode       = in_instr[6:0];
    assign funct3       = in_instr[14:12];
    assign funct7       = in_instr[31:25];
    assign is_alu_reg   = (opcode == OPCODE_ALU_REG);
    assign is_alu_imm   = (opcode == OPCODE_ALU_IMM);
    assign is_shift_imm = is_alu_imm && (funct3 == FUNCT3_SLL || funct3 == FUNCT3_SRL);
    // RV64 shift-immediates use instr[25] as the sixth shamt bit
    assign funct7_eff   = (N == 64 && is_alu_imm) ? {funct7[6:1], 1'b0} : funct7;

    always_comb begin
        dec           = '0;
        dec.pc        = in_pc;
        dec.rs1       = REG_W'(in_instr[19:15]);
        dec.rs2       = REG_W'(in_instr[24:20]);
        dec.rd        = REG_W'(in_instr[11:7]);
        dec.alu_funct = ALU_FUNCT_ADD;
        if (is_alu_reg || is_alu_imm) begin
            case (funct3)
                FUNCT3_ADD:  dec.alu_funct = (is_alu_reg && funct7 == FUNCT7_ALT1) ? ALU_FUNCT_SUB
                                                                                   : ALU_FUNCT_ADD;
                FUNCT3_SLL:  dec.alu_funct = ALU_FUNCT_SLL;
                FUNCT3_SLT:  dec.alu_funct = ALU_FUNCT_SLT;
                FUNCT3_SLTU: dec.alu_funct = ALU_FUNCT_SLTU;
                FUNCT3_XOR:  dec.alu_funct = ALU_FUNCT_XOR;
                FUNCT3_SRL:  begin
                    if (funct7_eff == FUNCT7_BASE)      dec.alu_funct = ALU_FUNCT_SRL;
                    else if (funct7_eff == FUNCT7_ALT1) dec.alu_funct = ALU_FUNCT_SRA;
                end
                FUNCT3_OR:   dec.alu_funct = ALU_FUNCT_OR;
                FUNCT3_AND:  dec.alu_funct = ALU_FUNCT_AND;
            endcase
            if (is_alu_reg && funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT1)
                dec.alu_funct = ALU_FUNCT_ADD;
        end

        case (opcode)
            OPCODE_ALU_IMM, OPCODE_LOAD, OPCODE_JALR:
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            OPCODE_STORE:
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OPCODE_BRANCH:
                imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            OPCODE_LUI, OPCODE_AUIPC:
                imm32 = {in_instr[31:12], 12'b0};
            OPCODE_JAL:
                imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        dec.immed = is_shift_imm ? N'(in_instr[20 +: SHAMT_W]) : N'($signed(imm32));

        dec.is_load     = (opcode == OPCODE_LOAD);
        dec.is_store    = (opcode == OPCODE_STORE);
        dec.is_branch   = (opcode == OPCODE_BRANCH);
        dec.is_jal      = (opcode == OPCODE_JAL);
        dec.is_jalr     = (opcode == OPCODE_JALR);
        dec.is_lui      = (opcode == OPCODE_LUI);
        dec.is_auipc    = (opcode == OPCODE_AUIPC);
        dec.alu_src_imm = !(is_alu_reg || dec.is_branch);
        dec.reg_write   = (is_alu_reg || is_alu_imm || dec.is_load || dec.is_lui || dec.is_auipc
                           || dec.is_jal || dec.is_jalr) && (in_instr[11:7] != 5'd0);

`ifdef DECODE_ILLEGAL_DETECT_EN
        dec.illegal = !(opcode inside {OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR,
                                       OPCODE_BRANCH, OPCODE_LOAD, OPCODE_STORE,
                                       OPCODE_ALU_IMM, OPCODE_ALU_REG})
                   || (is_alu_reg && funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT1)
                   || (is_alu_reg && funct7 == FUNCT7_ALT1
                       && funct3 != FUNCT3_ADD && funct3 != FUNCT3_SRL)
                   || (is_shift_imm && funct3 == FUNCT3_SLL && funct7_eff != FUNCT7_BASE)
                   || (is_shift_imm && funct3 == FUNCT3_SRL
                       && funct7_eff != FUNCT7_BASE && funct7_eff != FUNCT7_ALT1);
        if (dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
        end
`endif
    end

    logic in_ready_q,   in_ready_d;
    logic out_valid_q,  out_valid_d;
    logic skid_valid_q, skid_valid_d;
    dec_t out_q,        out_d;
    dec_t skid_q,       skid_d;
    logic accept;

    assign accept = in_valid && in_ready_q && !flush;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = dec;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = dec;
            end
        end else if (accept) begin
            // in_ready_q guarantees the skid slot is free here
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

`ifdef DECODE_ILLEGAL_DETECT_EN
    logic [7:0] illegal_count_q, illegal_count_d;

    always_comb begin
        illegal_count_d = illegal_count_q;
        if (out_valid_q && out_ready && out_q.illegal && illegal_count_q != 8'hFF)
            illegal_count_d = illegal_count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) illegal_count_q <= '0;
        else     illegal_count_q <= illegal_count_d;
    end

    assign illegal       = out_q.illegal;
    assign illegal_count = illegal_count_q;
`else
    assign illegal       = 1'b0;
    assign illegal_count = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign alu_funct   = out_q.alu_funct;
    assign rs1         = out_q.rs1;
    assign rs2         = out_q.rs2;
    assign rd          = out_q.rd;
    assign immed       = out_q.immed;
    assign alu_src_imm = out_q.alu_src_imm;
    assign reg_write   = out_q.reg_write;
    assign is_load     = out_q.is_load;
    assign is_store    = out_q.is_store;
    assign is_branch   = out_q.is_branch;
    assign is_jal      = out_q.is_jal;
    assign is_jalr     = out_q.is_jalr;
    assign is_lui      = out_q.is_lui;
    assign is_auipc    = out_q.is_auipc;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Scoreboard bench for decode_stage: hand-decoded instruction table,
//            occupancy model for handshake/skid behaviour, illegal counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_DETECT_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_SRA = 4'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  alu_funct;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] immed;
    logic        alu_src_imm, reg_write, is_load, is_store, is_branch;
    logic        is_jal, is_jalr, is_lui, is_auipc, illegal;
    logic [7:0]  illegal_count;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_funct(alu_funct), .rs1(rs1), .rs2(rs2), .rd(rd), .immed(immed),
        .alu_src_imm(alu_src_imm), .reg_write(reg_write), .is_load(is_load),
        .is_store(is_store), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .is_lui(is_lui), .is_auipc(is_auipc), .illegal(illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    // flags order: {alu_src_imm, reg_write, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc}
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  fn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [8:0]  flags;
        logic        ill;
    } exp_t;

    exp_t        prog [10];
    exp_t        sbq [$];
    exp_t        cur_exp;
    logic [31:0] pc_next = 32'h0000_1000;
    int          exp_cnt = 0;
    bit          last_acc;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic set_entry(input int i, input logic [31:0] instr, input logic [3:0] fn,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdx,
                             input logic [31:0] imm, input logic [8:0] flags, input logic ill);
        prog[i] = '{instr: instr, pc: 32'h0, fn: fn, rs1: r1, rs2: r2, rd: rdx,
                    imm: imm, flags: flags, ill: ill};
    endtask

    task automatic set_word(input int i);
        cur_exp    = prog[i];
        cur_exp.pc = pc_next;
        in_instr   = prog[i].instr;
        in_pc      = pc_next;
        pc_next    = pc_next + 32'd4;
    endtask

    task automatic check_outputs();
        check_eq("in_ready", in_ready, sbq.size() < 2);
        check_eq("out_valid", out_valid, sbq.size() > 0);
        check_eq("illegal_count", illegal_count, exp_cnt);
        if (sbq.size() > 0) begin
            check_eq("out_pc", out_pc, sbq[0].pc);
            check_eq("alu_funct", alu_funct, sbq[0].fn);
            check_eq("rs1", rs1, sbq[0].rs1);
            check_eq("rs2", rs2, sbq[0].rs2);
            check_eq("rd", rd, sbq[0].rd);
            check_eq("immed", immed, sbq[0].imm);
            check_eq("flags", {alu_src_imm, reg_write, is_load, is_store, is_branch,
                               is_jal, is_jalr, is_lui, is_auipc}, sbq[0].flags);
            check_eq("illegal", illegal, sbq[0].ill);
        end
    endtask

    // Check at the falling edge, then advance the model across the next rising edge.
    task automatic step();
        bit fire;
        @(negedge clk);
        check_outputs();
        fire     = (sbq.size() > 0) && out_ready;
        last_acc = in_valid && (sbq.size() < 2) && !flush && !rst;
        if (rst) begin
            sbq.delete();
            exp_cnt = 0;
        end else begin
            if (fire) begin
                if (sbq[0].ill && exp_cnt != 255) exp_cnt++;
                void'(sbq.pop_front());
            end
            if (flush)         sbq.delete();
            else if (last_acc) sbq.push_back(cur_exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_entry(0, 32'h00500093, FN_ADD, 5'd0, 5'd5,  5'd1,  32'd5,        9'b110000000, 1'b0);
        set_entry(1, 32'h40208133, FN_SUB, 5'd1, 5'd2,  5'd2,  32'd0,        9'b010000000, 1'b0);
        set_entry(2, 32'h4041d193, FN_SRA, 5'd3, 5'd4,  5'd3,  32'd4,        9'b110000000, 1'b0);
        set_entry(3, 32'hFE512E23, FN_ADD, 5'd2, 5'd5,  5'd28, 32'hFFFFFFFC, 9'b100100000, 1'b0);
        set_entry(4, 32'h0080A303, FN_ADD, 5'd1, 5'd8,  5'd6,  32'd8,        9'b111000000, 1'b0);
        set_entry(5, 32'hFE208CE3, FN_ADD, 5'd1, 5'd2,  5'd25, 32'hFFFFFFF8, 9'b000010000, 1'b0);
        set_entry(6, 32'h123453B7, FN_ADD, 5'd8, 5'd3,  5'd7,  32'h12345000, 9'b110000010, 1'b0);
        set_entry(7, 32'hFFDFF06F, FN_ADD, 5'd31, 5'd29, 5'd0, 32'hFFFFFFFC, 9'b100001000, 1'b0);
        set_entry(8, 32'h00A4F433, FN_AND, 5'd9, 5'd10, 5'd8,  32'd0,        9'b010000000, 1'b0);
        set_entry(9, 32'h0000007F, FN_ADD, 5'd0, 5'd0,  5'd0,  32'd0,        9'b100000000, ILL_EN);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_word(0);
        step();
        step();
        check_eq("rst_out_pc", out_pc, 32'd0);
        check_eq("rst_immed", immed, 32'd0);
        check_eq("rst_alu_funct", alu_funct, 4'd0);
        check_eq("rst_rd", rd, 5'd0);
        check_eq("rst_flags", {alu_src_imm, reg_write, is_load, is_store, is_branch,
                               is_jal, is_jalr, is_lui, is_auipc}, 9'd0);
        rst = 1'b0;

        // back-to-back stream at full throughput
        for (int i = 0; i < 10; i++) begin
            set_word(i);
            in_valid = 1'b1;
            step();
            check_eq("stream_accept", last_acc, 1'b1);
        end
        in_valid = 1'b0;
        repeat (3) step();

        // backpressure: word 1 held, word 2 in skid, word 3 waits
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_word(i);
            in_valid = 1'b1;
            step();
        end
        set_word(2);
        repeat (3) step();
        out_ready = 1'b1;
        for (int k = 0; k < 8 && !last_acc; k++) step();
        check_eq("bp_word3_accepted", last_acc, 1'b1);
        in_valid = 1'b0;
        repeat (4) step();

        // random handshake traffic
        begin
            int idx = 0;
            set_word(idx);
            for (int c = 0; c < 80; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = ($urandom_range(0, 3) != 0);
                step();
                if (last_acc) begin
                    idx = (idx + 1) % 10;
                    set_word(idx);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        // flush with both registers full and input valid
        out_ready = 1'b0;
        for (int i = 3; i < 6; i++) begin
            set_word(i);
            in_valid = 1'b1;
            step();
        end
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check_eq("flush_out_valid", out_valid, 1'b0);
        check_eq("flush_in_ready", in_ready, 1'b1);
        // flush while empty and ready drops the offered word
        set_word(6);
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // illegal stream: counter saturates, reset clears it
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            set_word(9);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check_eq("illegal_count_sat", illegal_count, ILL_EN ? 8'd255 : 8'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_eq("illegal_count_rst", illegal_count, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction-decode stage sitting between fetch and the register-file/ALU stage of the philv core. It is a parametrised successor of the combinational decoder:
- covers all RV32I/RV64I base formats (R/I/S/B/U/J);
- adds per-instruction control flags and a valid/ready pipeline register with a one-entry skid buffer;
- supports flush.

Throughput is one instruction per cycle with one cycle of latency.

## Interface
Parameters:
- `N`, 32, datapath/immediate width; legal values 32 or 64.
- `REG_W`, 5, register-index width.

Ports:
- `clk`  in  1  clock. One clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `flush`  in  1  discards all held instructions and any input accepted in the same cycle.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept; registered, equal to `!skid_valid`.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  N  PC of `in_instr`.
- `out_valid`  out  1  decoded instruction present.
- `out_ready`  in  1  downstream accepts.
- `out_pc`  out  N  PC of the decoded instruction.
- `alu_funct`  out  `ALU_FUNCT_WIDTH`  `ALU_FUNCT_*` code.
- `rs1`, `rs2`, `rd`  out  `REG_W`  register indices.
- `immed`  out  N  format-selected, sign-extended immediate.
- `alu_src_imm`, `reg_write`, `is_load`, `is_store`, `is_branch`, `is_jal`, `is_jalr`, `is_lui`, `is_auipc`  out  1  control flags.
- `illegal`  out  1  decoded word is illegal (only with the macro; otherwise tied to 0).
- `illegal_count`  out  8  saturating count of illegal instructions delivered (only with the macro; otherwise tied to 0).

## Operation
- **Decode is combinational from `in_instr`; results are captured into registers.**
- **`alu_funct` selection**
  - Opcode other than `OPCODE_ALU_REG`/`OPCODE_ALU_IMM`: `ALU_FUNCT_ADD`.
  - ALU_REG with funct3 ADD: funct7 BASE gives ADD, ALT1 gives SUB.
  - ALU_IMM with funct3 ADD: always ADD (funct7 is immediate bits).
  - funct3 SRL (both opcodes): funct7 BASE gives SRL, ALT1 gives SRA.
  - AND/OR/XOR/SLT/SLTU/SLL map directly.
  - Any unlisted funct7 gives ADD. The output is fully defined for all inputs.
- **`immed` selection**
  - I-type (ALU_IMM, LOAD, JALR): `instr[31:20]` sign-extended.
  - Shift-immediates (ALU_IMM with funct3 SLL/SRL): `instr[20 +: $clog2(N)]` zero-extended.
  - STORE: `{instr[31:25], instr[11:7]}` sign-extended.
  - BRANCH: `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}` sign-extended.
  - LUI/AUIPC: `{instr[31:12], 12'b0}` sign-extended.
  - JAL: `{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}` sign-extended.
  - ALU_REG and others: 0.
- **Index fields:** `rs1 = instr[19:15]`, `rs2 = instr[24:20]`, `rd = instr[11:7]`, zero-padded to `REG_W`.
- **Flags**
  - `reg_write` = ALU_REG | ALU_IMM | LOAD | LUI | AUIPC | JAL | JALR, forced 0 when `rd == 0`.
  - `alu_src_imm` = every opcode except ALU_REG and BRANCH.
- **Buffering:** one output register plus one skid register (instruction, PC and all decoded fields).
  - Input accept = `in_valid && in_ready && !flush`.
  - If the output register is empty or is being drained (`out_ready`), an accepted word goes to the output register. Otherwise it goes to the skid register.
  - When the output drains and the skid register is full, the skid contents move to the output register and the skid register empties. A new accept in that same cycle goes into the skid register.
  - Ordering is strictly FIFO.

## Timing
- **Reset:** all outputs 0, `in_ready` = 1, `illegal_count` = 0. Reset takes priority over flush and accept.
- **Latency:** an instruction accepted in cycle t appears with `out_valid` = 1 in cycle t+1.
- **Hold:** while `out_valid && !out_ready`, every output is held stable.
- **`in_ready`** falls the cycle after the skid register fills and rises the cycle after it empties. Upstream never sees combinational ready.
- **Flush:** `out_valid` = 0 and skid empty next cycle; `in_ready` = 1 next cycle. Flush with simultaneous accept drops the input.
- **Full throughput:** a back-to-back stream with `out_ready` = 1 stays at one instruction per cycle with no bubbles.

## Configuration
- **`DECODE_ILLEGAL_DETECT_EN` defined:** `illegal` asserts for any of the following:
  - unknown opcode;
  - ALU_REG with funct7 not BASE/ALT1;
  - ALU_REG funct7 ALT1 with funct3 other than ADD/SRL;
  - shift-immediate with bad funct7 (or `instr[25]` set when N=32).
- **Effect of an illegal word:**
  - `reg_write`, `is_load`, `is_store` are forced 0.
  - `illegal_count` increments by 1 when the illegal instruction leaves (`out_valid && out_ready`) and saturates at 255.
  - Flush does not clear the count; only `rst` does.
- **Undefined:** `illegal` and `illegal_count` are constant 0 and no detect logic is built.

## Test plan
- **addi:** reset, then `0x00500093` (addi x1,x0,5). Next cycle: `out_valid` = 1, `alu_funct` = ADD, `rd` = 1, `immed` = 5, `reg_write` = 1, `alu_src_imm` = 1.
- **sub / srai:** `0x40208133` (sub x2,x1,x2) gives SUB with `alu_src_imm` = 0. `0x4041d193` (srai x3,x3,4) gives SRA with `immed` = 4.
- **sw:** `0xFE512E23` (sw x5,-4(x2)) gives `immed` = 0xFFFFFFFC, `is_store` = 1, `reg_write` = 0, `rs1` = 2, `rs2` = 5.
- **Backpressure:** hold `out_ready` = 0 and send 3 words.
  - Word 1 is held on the outputs, word 2 is in skid, and `in_ready` = 0 from the cycle after.
  - Release `out_ready`: order is 1, 2, 3 with no loss or duplication.
- **Flush:** assert `flush` with both registers full and `in_valid` = 1. Next cycle `out_valid` = 0 and `in_ready` = 1; the flushed words never appear.
- **Illegal detect (macro on):** stream 300 words of `0x0000007F`. `illegal` = 1 on each, `reg_write` = 0, `illegal_count` saturates at 255; `rst` clears it to 0.
